// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants, widths and adjust-select encodings for the time-of-day counter
package clock_pkg;

   localparam int HOUR_W = 5;
   localparam int BCD_W  = 7;

   localparam logic [HOUR_W-1:0] HOUR_MAX  = 5'd23;
   localparam logic [2:0]        TENS_MAX  = 3'd5;
   localparam logic [3:0]        UNITS_MAX = 4'd9;

   typedef enum logic [1:0] {
      ADJ_NONE = 2'b00,
      ADJ_HOUR = 2'b01,
      ADJ_MIN  = 2'b10,
      ADJ_SEC  = 2'b11
   } adj_sel_e;

   // Next value of a BCD 00-59 field, wrapping 59 back to 00.
   function automatic logic [BCD_W-1:0] bcd60_inc(input logic [BCD_W-1:0] v);
      if (v[3:0] >= UNITS_MAX) begin
         if (v[6:4] >= TENS_MAX) return '0;
         else                    return {v[6:4] + 3'd1, 4'd0};
      end
      return {v[6:4], v[3:0] + 4'd1};
   endfunction

endpackage

// File: rtl/bcd_mod60_counter.sv
// rtl/bcd_mod60_counter.sv - 7-bit BCD 00-59 counter with optional carry-out on wrap
module bcd_mod60_counter
   import clock_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic             carry_en,
   output logic [BCD_W-1:0] value,
   output logic             carry
);

   logic [BCD_W-1:0] value_d;
   logic [BCD_W-1:0] value_q;

   // Next value: clear dominates, otherwise step by one with wrap inside 00-59.
   always_comb begin
      value_d = value_q;
      if (clr)      value_d = '0;
      else if (inc) value_d = bcd60_inc(value_q);
   end

   // Field register.
   always_ff @(posedge clk) begin
      if (rst) value_q <= '0;
      else     value_q <= value_d;
   end

   // Carry only for counted wraps; adjust increments leave carry_en low.
   assign carry = inc && carry_en && !clr && (value_q == {TENS_MAX, UNITS_MAX});
   assign value = value_q;

endmodule

// File: rtl/clock_time_counter.sv
// rtl/clock_time_counter.sv - hh:mm:ss time-of-day counter with prescaler, set mode and clear
module clock_time_counter
   import clock_pkg::*;
#(
   parameter int TICK_DIV = 50000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              clr,
   input  logic [1:0]        adj_sel,
   input  logic              adj_inc,
   output logic [HOUR_W-1:0] hour,
   output logic [BCD_W-1:0]  minute,
   output logic [BCD_W-1:0]  second,
   output logic              sec_tick,
   output logic              day_wrap
);

   localparam int               CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0]  cnt_d, cnt_q;
   logic [HOUR_W-1:0] hour_d, hour_q;
   logic              sec_tick_d, sec_tick_q;
   logic              day_wrap_d, day_wrap_q;

   logic set_mode, adj_on, tick, tick_eff;
   logic sec_inc, sec_carry, min_inc, min_carry, hour_inc;

   assign set_mode = (adj_sel != ADJ_NONE);
   assign adj_on   = adj_inc && set_mode;
   assign tick     = run && !set_mode && (cnt_q == CNT_LAST);
   assign tick_eff = tick && !clr;

   assign sec_inc  = tick_eff || (adj_on && adj_sel == ADJ_SEC);
   assign min_inc  = sec_carry || (adj_on && adj_sel == ADJ_MIN);
   assign hour_inc = min_carry || (adj_on && adj_sel == ADJ_HOUR);

   bcd_mod60_counter u_second (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .inc      (sec_inc),
      .carry_en (tick_eff),
      .value    (second),
      .carry    (sec_carry)
   );

   bcd_mod60_counter u_minute (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .inc      (min_inc),
      .carry_en (tick_eff),
      .value    (minute),
      .carry    (min_carry)
   );

   // Prescaler, hour field and the registered event pulses.
   always_comb begin
      cnt_d = cnt_q;
      if (clr || set_mode) cnt_d = '0;
      else if (run)        cnt_d = tick ? '0 : cnt_q + 1'b1;

      hour_d = hour_q;
      if (clr)           hour_d = '0;
      else if (hour_inc) hour_d = (hour_q >= HOUR_MAX) ? '0 : hour_q + 1'b1;

      sec_tick_d = tick_eff;
      day_wrap_d = min_carry && (hour_q == HOUR_MAX);
   end

   // State update with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         hour_q     <= '0;
         sec_tick_q <= 1'b0;
         day_wrap_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         hour_q     <= hour_d;
         sec_tick_q <= sec_tick_d;
         day_wrap_q <= day_wrap_d;
      end
   end

   assign hour     = hour_q;
   assign sec_tick = sec_tick_q;
   assign day_wrap = day_wrap_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// tb/tb_clock_time_counter.sv - directed self-checking bench for clock_time_counter with TICK_DIV=4
module tb_clock_time_counter;

   logic       clk = 1'b0;
   logic       rst, run, clr, adj_inc;
   logic [1:0] adj_sel;
   logic [4:0] hour;
   logic [6:0] minute, second;
   logic       sec_tick, day_wrap;

   int checks = 0;
   int errors = 0;

   clock_time_counter #(.TICK_DIV(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .clr      (clr),
      .adj_sel  (adj_sel),
      .adj_inc  (adj_inc),
      .hour     (hour),
      .minute   (minute),
      .second   (second),
      .sec_tick (sec_tick),
      .day_wrap (day_wrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_time(input string tag, input logic [4:0] h, input logic [6:0] m, input logic [6:0] s);
      chk({tag, "_hour"},   32'(hour),   32'(h));
      chk({tag, "_minute"}, 32'(minute), 32'(m));
      chk({tag, "_second"}, 32'(second), 32'(s));
   endtask

   task automatic adj(input logic [1:0] sel, input int n);
      adj_sel = sel;
      for (int i = 0; i < n; i++) begin
         adj_inc = 1'b1;
         step();
         adj_inc = 1'b0;
         step();
      end
   endtask

   task automatic wait_tick(input string tag, input int exp_cycles);
      int n = 0;
      do begin
         step();
         n++;
      end while (!sec_tick && n < 12);
      chk({tag, "_latency"}, 32'(n), 32'(exp_cycles));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; run = 1'b0; clr = 1'b0; adj_sel = 2'b00; adj_inc = 1'b0;
      @(negedge clk);
      step();
      step();
      chk_time("reset", 5'd0, 7'h00, 7'h00);
      chk("reset_sec_tick", 32'(sec_tick), 32'd0);
      chk("reset_day_wrap", 32'(day_wrap), 32'd0);

      // Free running: tick every fourth cycle.
      rst = 1'b0; run = 1'b1;
      wait_tick("run1", 4);
      chk("run1_second", 32'(second), 32'h01);
      step();
      chk("run1_pulse_width", 32'(sec_tick), 32'd0);
      wait_tick("run2", 3);
      chk("run2_second", 32'(second), 32'h02);

      // Set 09:09:59 then tick into 09:10:00.
      clr = 1'b1; step(); clr = 1'b0;
      chk_time("clr0", 5'd0, 7'h00, 7'h00);
      adj(2'b01, 9);
      adj(2'b10, 9);
      adj(2'b11, 59);
      chk_time("set_09_09_59", 5'd9, 7'h09, 7'h59);
      chk("set_no_tick", 32'(sec_tick), 32'd0);
      adj_sel = 2'b00;
      wait_tick("carry_min", 4);
      chk_time("t_09_10_00", 5'd9, 7'h10, 7'h00);
      wait_tick("after_carry1", 4);
      chk("after_carry1_second", 32'(second), 32'h01);
      wait_tick("after_carry2", 4);
      chk("after_carry2_second", 32'(second), 32'h02);

      // Day rollover from 23:59:58.
      clr = 1'b1; step(); clr = 1'b0;
      adj(2'b01, 23);
      adj(2'b10, 59);
      adj(2'b11, 58);
      adj_sel = 2'b00;
      wait_tick("pre_wrap", 4);
      chk_time("t_23_59_59", 5'd23, 7'h59, 7'h59);
      chk("pre_wrap_day_wrap", 32'(day_wrap), 32'd0);
      wait_tick("wrap", 4);
      chk_time("t_wrap", 5'd0, 7'h00, 7'h00);
      chk("wrap_day_wrap", 32'(day_wrap), 32'd1);
      step();
      chk("wrap_day_wrap_width", 32'(day_wrap), 32'd0);

      // Adjust wraps stay inside their field.
      run = 1'b0;
      clr = 1'b1; step(); clr = 1'b0;
      adj(2'b11, 59);
      chk("adj_sec_59", 32'(second), 32'h59);
      adj(2'b11, 1);
      chk("adj_sec_wrap", 32'(second), 32'h00);
      chk("adj_sec_wrap_minute", 32'(minute), 32'h00);
      adj(2'b01, 23);
      chk("adj_hour_23", 32'(hour), 32'd23);
      adj_sel = 2'b01; adj_inc = 1'b1; step(); adj_inc = 1'b0;
      chk("adj_hour_wrap", 32'(hour), 32'd0);
      chk("adj_hour_wrap_day_wrap", 32'(day_wrap), 32'd0);
      chk("adj_hour_wrap_sec_tick", 32'(sec_tick), 32'd0);
      adj(2'b10, 3);
      chk("adj_min_3", 32'(minute), 32'h03);
      adj_sel = 2'b00; adj_inc = 1'b1; step(); adj_inc = 1'b0;
      chk_time("adj_none_ignored", 5'd0, 7'h03, 7'h00);

      // Hold at prescaler count 2.
      clr = 1'b1; step(); clr = 1'b0;
      run = 1'b1;
      step(); step();
      run = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk_time("hold", 5'd0, 7'h00, 7'h00);
      chk("hold_sec_tick", 32'(sec_tick), 32'd0);
      run = 1'b1;
      wait_tick("resume", 2);
      chk("resume_second", 32'(second), 32'h01);

      // Clear coincident with a tick.
      step(); step(); step();
      clr = 1'b1; step(); clr = 1'b0;
      chk_time("clr_on_tick", 5'd0, 7'h00, 7'h00);
      chk("clr_on_tick_sec_tick", 32'(sec_tick), 32'd0);
      chk("clr_on_tick_day_wrap", 32'(day_wrap), 32'd0);
      wait_tick("after_clr", 4);

      // Reset at 12:34:56 mid-count.
      adj(2'b01, 12);
      adj(2'b10, 34);
      adj(2'b11, 55);
      chk_time("set_12_34_56", 5'd12, 7'h34, 7'h56);
      adj_sel = 2'b00;
      step(); step();
      rst = 1'b1; step(); rst = 1'b0;
      chk_time("rst_mid", 5'd0, 7'h00, 7'h00);
      chk("rst_mid_sec_tick", 32'(sec_tick), 32'd0);
      wait_tick("after_rst", 4);
      chk("after_rst_second", 32'(second), 32'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
